// File: rtl/reset_seq_pkg.sv
// Shared encodings and helpers for the multi-channel reset sequencer.
package reset_seq_pkg;

  localparam logic [2:0] S_WAIT_LOCK = 3'd0;
  localparam logic [2:0] S_FILTER    = 3'd1;
  localparam logic [2:0] S_INIT      = 3'd2;
  localparam logic [2:0] S_STEP      = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  // Width needed to index n channels; never less than one bit so a
  // single-channel build still has a legal vector.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Two-flop synchroniser with asynchronous active-high clear.
module reset_seq_sync (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;

  // Capture the asynchronous input and let metastability settle for one cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: qualifies lock, waits an init delay, then
// releases NUM_CH resets in order, STEP_CYCLES apart.
//
// state       | meaning
// S_WAIT_LOCK | all resets held, waiting for synchronised lock
// S_FILTER    | lock must stay high for LOCK_FILTER cycles
// S_INIT      | init delay before channel 0 release
// S_STEP      | releasing channels 1..NUM_CH-1, one per step period
// S_RUN       | all channels released, sequence complete
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int INIT_CYCLES = 100000000,
  parameter int STEP_CYCLES = 100000,
  parameter int LOCK_FILTER = 1000,
  parameter int TIMER_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lock_in,
  input  logic              restart,
  output logic [NUM_CH-1:0] reset_out,
  output logic              seq_done,
  output logic              busy
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam longint TIMER_MAX = (longint'(1) << TIMER_W) - longint'(1);

  generate
    if (longint'(INIT_CYCLES) > TIMER_MAX || longint'(STEP_CYCLES) > TIMER_MAX ||
        longint'(LOCK_FILTER) > TIMER_MAX) begin : g_timer_too_narrow
      $error("reset_sequencer: TIMER_W too narrow for the configured delays");
    end
  endgenerate

  localparam logic [TIMER_W-1:0] LF_LOAD   = TIMER_W'(LOCK_FILTER - 1);
  localparam logic [TIMER_W-1:0] INIT_LOAD = TIMER_W'(INIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STEP_LOAD = TIMER_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_CH - 1);

  logic              lock_s;
  logic              fault;
  logic [2:0]        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] reset_out_q, reset_out_d;
  logic              seq_done_q, seq_done_d;

  reset_seq_sync u_lock_sync (
    .clk (clk),
    .clr (reset),
    .d   (lock_in),
    .q   (lock_s)
  );

  // Lock loss or a restart aborts the sequence from anywhere but the idle wait.
  assign fault = (state_q != S_WAIT_LOCK) && (!lock_s || restart);

  // Next-state, timer, channel index and output computation.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    reset_out_d = reset_out_q;
    seq_done_d  = seq_done_q;
    if (fault) begin
      // Abort wins over any timer expiry on the same edge.
      reset_out_d = '1;
      seq_done_d  = 1'b0;
      idx_d       = '0;
      if (!lock_s) begin
        state_d = S_WAIT_LOCK;
      end else begin
        state_d = S_FILTER;
        timer_d = LF_LOAD;
      end
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          reset_out_d = '1;
          seq_done_d  = 1'b0;
          if (lock_s) begin
            timer_d = LF_LOAD;
            state_d = S_FILTER;
          end
        end
        S_FILTER: begin
          if (timer_q == '0) begin
            timer_d = INIT_LOAD;
            state_d = S_INIT;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        S_INIT: begin
          if (timer_q == '0) begin
            reset_out_d[0] = 1'b0;
            idx_d          = IDX_W'(1);
            if (NUM_CH == 1) begin
              seq_done_d = 1'b1;
              state_d    = S_RUN;
            end else begin
              timer_d = STEP_LOAD;
              state_d = S_STEP;
            end
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        S_STEP: begin
          if (timer_q == '0) begin
            reset_out_d[idx_q] = 1'b0;
            if (idx_q == IDX_LAST) begin
              seq_done_d = 1'b1;
              state_d    = S_RUN;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              timer_d = STEP_LOAD;
            end
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        S_RUN: begin
          reset_out_d = '0;
          seq_done_d  = 1'b1;
        end
        default: begin
          reset_out_d = '1;
          seq_done_d  = 1'b0;
          state_d     = S_WAIT_LOCK;
        end
      endcase
    end
  end

  // Sequencer registers; outputs come straight from these flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT_LOCK;
      timer_q     <= '0;
      idx_q       <= '0;
      reset_out_q <= '1;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      reset_out_q <= reset_out_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign reset_out = reset_out_q;
  assign seq_done  = seq_done_q;
  assign busy      = ~seq_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: expected output values are queued per edge
// number when a scenario is set up and popped as the edges are reached.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int NUM_CH      = 3;
  localparam int INIT_CYCLES = 20;
  localparam int STEP_CYCLES = 5;
  localparam int LOCK_FILTER = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              lock_in = 1'b0;
  logic              restart = 1'b0;
  logic [NUM_CH-1:0] reset_out;
  logic              seq_done;
  logic              busy;

  typedef struct {
    int         edge_n;
    logic [4:0] exp;
    string      tag;
  } sb_t;

  sb_t sb_q[$];
  int  edge_n;
  int  n_cmp = 0;
  int  n_err = 0;

  reset_sequencer #(
    .NUM_CH      (NUM_CH),
    .INIT_CYCLES (INIT_CYCLES),
    .STEP_CYCLES (STEP_CYCLES),
    .LOCK_FILTER (LOCK_FILTER),
    .TIMER_W     (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lock_in   (lock_in),
    .restart   (restart),
    .reset_out (reset_out),
    .seq_done  (seq_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, obs, exp);
    end
  endtask

  // Packs {busy, seq_done, reset_out}; busy is always the inverse of done.
  function automatic logic [4:0] ev(input logic [2:0] ro, input logic done);
    return {~done, done, ro};
  endfunction

  task automatic push(input int n, input logic [2:0] ro, input logic done, input string tag);
    sb_t e;
    e.edge_n = n;
    e.exp    = ev(ro, done);
    e.tag    = tag;
    sb_q.push_back(e);
  endtask

  // Release of channel 0 at base, channel 1 at base+STEP, channel 2 at base+2*STEP,
  // each checked one edge early (still held) and on the release edge.
  task automatic push_release(input int base, input string pfx);
    push(base - 1,                 3'b111, 1'b0, {pfx, "_ch0_hold"});
    push(base,                     3'b110, 1'b0, {pfx, "_ch0_rel"});
    push(base + STEP_CYCLES - 1,   3'b110, 1'b0, {pfx, "_ch1_hold"});
    push(base + STEP_CYCLES,       3'b100, 1'b0, {pfx, "_ch1_rel"});
    push(base + 2*STEP_CYCLES - 1, 3'b100, 1'b0, {pfx, "_ch2_hold"});
    push(base + 2*STEP_CYCLES,     3'b000, 1'b1, {pfx, "_ch2_rel"});
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0 && sb_q[0].edge_n == edge_n) begin
      e = sb_q.pop_front();
      chk(e.tag, 32'({busy, seq_done, reset_out}), 32'(e.exp));
    end
    edge_n++;
  endtask

  // Anything left in the queue was never reached within the edge budget.
  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, "_timeout"}, 32'(edge_n), 32'(e.edge_n));
    end
  endtask

  // Holds reset for two edges, checks the reset state, then releases it
  // mid-cycle so the next rising edge is edge 0.
  task automatic do_reset(input string tag);
    reset   = 1'b1;
    lock_in = 1'b0;
    restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(tag, 32'({busy, seq_done, reset_out}), 32'(ev(3'b111, 1'b0)));
    reset  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    // Nominal, then lock loss in S_RUN and relock.
    // lock_in drops just after edge 100 (first sampled low at 101) and
    // returns before edge 110 (first sampled high at 110).
    do_reset("a_reset");
    push_release(30, "nom");
    push(102, 3'b000, 1'b1, "loss_still_run");
    push(103, 3'b111, 1'b0, "loss_reassert");
    push_release(140, "relock");
    for (int n = 0; n <= 150; n++) begin
      lock_in = !(n >= 101 && n < 110);
      tick();
    end
    drain();

    // One-cycle lock glitch sampled at edge 5 restarts the filter.
    do_reset("b_reset");
    push_release(36, "glitch");
    for (int n = 0; n <= 47; n++) begin
      lock_in = (n != 5);
      tick();
    end
    drain();

    // Restart pulse sampled at edge 38 while in S_STEP.
    do_reset("c_reset");
    push(30, 3'b110, 1'b0, "rs_ch0_rel");
    push(35, 3'b100, 1'b0, "rs_ch1_rel");
    push(37, 3'b100, 1'b0, "rs_pre");
    push(38, 3'b111, 1'b0, "rs_reassert");
    push_release(66, "rs_rerun");
    for (int n = 0; n <= 80; n++) begin
      lock_in = 1'b1;
      restart = (n == 38);
      tick();
    end
    restart = 1'b0;
    drain();

    // Async reset mid-sequence, then full nominal timing from scratch.
    do_reset("d_reset");
    push(29, 3'b111, 1'b0, "d_ch0_hold");
    push(30, 3'b110, 1'b0, "d_ch0_rel");
    for (int n = 0; n <= 33; n++) begin
      lock_in = 1'b1;
      tick();
    end
    drain();
    #3;
    reset = 1'b1;
    #1;
    chk("d_async_immediate", 32'({busy, seq_done, reset_out}), 32'(ev(3'b111, 1'b0)));
    do_reset("d_reset2");
    push_release(30, "d_rerun");
    for (int n = 0; n <= 41; n++) begin
      lock_in = 1'b1;
      tick();
    end
    drain();

    // Lock drop (sampled low at 33, seen by the FSM at 35) together with a
    // restart, both landing on channel 1's expiry edge.
    do_reset("e_reset");
    push(30, 3'b110, 1'b0, "e_ch0_rel");
    push(34, 3'b110, 1'b0, "e_ch1_hold");
    push(35, 3'b111, 1'b0, "e_abort");
    push(36, 3'b111, 1'b0, "e_held");
    push(60, 3'b111, 1'b0, "e_held_late");
    for (int n = 0; n <= 60; n++) begin
      lock_in = (n < 33);
      restart = (n == 35);
      tick();
    end
    restart = 1'b0;
    drain();
    chk("e_state", 32'(dut.state_q), 32'(S_WAIT_LOCK));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Multi-channel power-up reset sequencer. Generalises the fixed one-shot 1-second startup delay.
- Holds NUM_CH active-high reset outputs asserted until an external lock indication (e.g. QPLL/MMCM locked) has been stable for a filter period, then waits INIT_CYCLES.
- Then releases channel 0, 1, ... NUM_CH-1 in order, STEP_CYCLES apart.
- Loss of lock or a restart request re-asserts every channel and reruns the sequence. Sits between the clocking/PLL logic and the CMAC/transceiver/user-logic resets.

Parameters:
- NUM_CH, 4: number of reset outputs released in sequence (>=1).
- INIT_CYCLES, 100000000: delay from lock qualified to reset_out[0] release (1 s at 100 MHz, >=1).
- STEP_CYCLES, 100000: delay between consecutive channel releases (>=1).
- LOCK_FILTER, 1000: consecutive synchronised-high lock cycles required (>=1).
- TIMER_W, 32: countdown timer width. Must hold max(INIT_CYCLES, STEP_CYCLES, LOCK_FILTER); elaboration error otherwise.

Ports:
- clk  input  1  sole clock.
- reset  input  1  asynchronous, active-high reset.
- lock_in  input  1  asynchronous lock indication; synchronised internally.
- restart  input  1  synchronous single-cycle request to rerun the sequence.
- reset_out  output  NUM_CH  per-channel active-high resets, registered.
- seq_done  output  1  high when all channels are released.
- busy  output  1  high whenever seq_done is low.

Behaviour:
- Async reset: reset_out = all 1s, seq_done = 0, busy = 1, state = S_WAIT_LOCK, synchroniser flops = 0, timer = 0, channel index = 0.
- lock_in passes a 2-flop synchroniser. lock_s is valid 2 edges after lock_in is sampled.
- S_WAIT_LOCK:
  - reset_out all 1s.
  - When lock_s = 1: load timer = LOCK_FILTER-1 and go to S_FILTER.
- S_FILTER:
  - While lock_s = 1: decrement; at timer == 0, load INIT_CYCLES-1 and go to S_INIT.
  - lock_s = 0: back to S_WAIT_LOCK.
- S_INIT:
  - Decrement.
  - At timer == 0: clear reset_out[0] and set idx = 1.
  - If NUM_CH == 1, go to S_RUN. Otherwise load STEP_CYCLES-1 and go to S_STEP.
- S_STEP:
  - Decrement.
  - At timer == 0: clear reset_out[idx].
  - If idx == NUM_CH-1, go to S_RUN. Otherwise increment idx and reload STEP_CYCLES-1.
- S_RUN:
  - reset_out all 0s, seq_done = 1.
  - Holds until a fault.
- Fault (lock_s = 0 or restart = 1), in any state except S_WAIT_LOCK:
  - Takes effect on the next edge and has priority over any timer expiry on the same edge.
  - reset_out all 1s, seq_done = 0, idx = 0.
  - Next state: S_WAIT_LOCK if lock_s = 0, else S_FILTER with timer = LOCK_FILTER-1.
  - lock drop and restart together behave as lock drop.
- restart in S_WAIT_LOCK: ignored.
- Release order:
  - Released channels stay released until a fault.
  - Channel k is never released while channel k-1 is asserted.
- Timing contract, with lock_in held high from edge E0 (first edge sampling it high):
  - reset_out[0] falls at edge E0 + 2 + LOCK_FILTER + INIT_CYCLES.
  - reset_out[k] falls STEP_CYCLES edges after reset_out[k-1].
  - seq_done rises on the same edge as reset_out[NUM_CH-1] falls.
- Lock loss: reset_out re-asserts 3 edges after lock_in is first sampled low (2 synchroniser edges + 1 register edge).
- Output glitching: reset_out bits driven directly from flops; no combinational path from any input.

Decomposition:
- Shared package reset_seq_pkg: state encodings (S_WAIT_LOCK, S_FILTER, S_INIT, S_STEP, S_RUN) as localparams; clog2 helper for idx width.
- One sub-module: reset_seq_sync, a 2-flop synchroniser with async active-high clear and ASYNC_REG attributes. Used for lock_in.
- Timer, idx and FSM stay in the top module.

Test Plan:
- All scenarios use NUM_CH=3, INIT_CYCLES=20, STEP_CYCLES=5, LOCK_FILTER=8.
- Nominal: reset released, lock_in high from edge 0 -> reset_out[0] falls at edge 30, [1] at 35, [2] at 40; seq_done rises at 40; busy falls at 40.
- Lock glitch in filter: lock_in low for one cycle at edge 5 -> filter restarts; reset_out[0] falls at edge 36 (6 + 30).
- Lock loss in S_RUN: lock_in low at edge 100 -> reset_out = 3'b111 and seq_done = 0 at edge 103. Lock back high at edge 110 -> reset_out[0] falls at 140.
- Restart in S_STEP: restart pulse at edge 37, lock high -> reset_out = 3'b111 at edge 38. Sequence restarts from S_FILTER; reset_out[0] falls at edge 66.
- Async reset mid-sequence: assert reset between edges 33 and 34 -> reset_out = 3'b111 immediately, before the next edge. Deassert with lock high -> full nominal timing from scratch.
- Simultaneous restart and lock drop at the timer-expiry edge for channel 1 -> channel 1 never releases; state S_WAIT_LOCK; all resets asserted.
